cpu_rd_data_pio: RTL



---
 rtl/cpu_rd_data_pio.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cpu_rd_data_pio.sv
// Avalon-MM input PIO: synchronizes in_port, captures per-bit edges (W1C) and raises a maskable level irq.
// Optional build macro CPU_RD_DATA_PIO_SNAPSHOT_EN turns address 1 into a first-event snapshot register.
module cpu_rd_data_pio #(
    parameter int DATA_WIDTH  = 24,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    localparam logic [2:0] SETTLE_INIT = 3'(SYNC_STAGES + 1);

    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] data_in_s;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [2:0]            settle_q;
    logic [2:0]            settle_d;
    logic [DATA_WIDTH-1:0] edge_raw_s;
    logic [DATA_WIDTH-1:0] edge_s;
    logic [DATA_WIDTH-1:0] irq_mask_q;
    logic [DATA_WIDTH-1:0] irq_mask_d;
    logic [DATA_WIDTH-1:0] edge_capture_q;
    logic [DATA_WIDTH-1:0] edge_capture_d;
    logic [DATA_WIDTH-1:0] clr_s;
    logic [DATA_WIDTH-1:0] snap_rd_s;
    logic [31:0]           readdata_q;
    logic [31:0]           readdata_d;
    logic                  irq_q;
    logic                  irq_d;
    logic                  wr_s;
    logic                  rd_s;
    logic                  unused_wdata_s;

    assign data_in_s      = sync_q[SYNC_STAGES-1];
    assign wr_s           = chipselect & ~write_n;
    assign rd_s           = chipselect & read;
    assign unused_wdata_s = ^writedata;
    assign readdata       = readdata_q;
    assign irq            = irq_q;

    // Synchronizer chain and one-cycle delayed copy of the synchronized bus
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= {DATA_WIDTH{1'b0}};
            end
            prev_q <= {DATA_WIDTH{1'b0}};
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= data_in_s;
        end
    end

    // Settle counter next state: count down to zero and stay there
    always_comb begin
        settle_d = settle_q;
        if (settle_q != 3'd0) begin
            settle_d = settle_q - 3'd1;
        end else begin
            settle_d = 3'd0;
        end
    end

    // Edge selection; suppressed until the synchronizer holds live data
    always_comb begin
        edge_raw_s = {DATA_WIDTH{1'b0}};
        case (EDGE_TYPE)
            0:       edge_raw_s = data_in_s & ~prev_q;
            1:       edge_raw_s = ~data_in_s & prev_q;
            default: edge_raw_s = (data_in_s & ~prev_q) | (~data_in_s & prev_q);
        endcase
        if (settle_q == 3'd0) begin
            edge_s = edge_raw_s;
        end else begin
            edge_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Register writes, capture update and irq next state (edge beats clear)
    always_comb begin
        irq_mask_d = irq_mask_q;
        clr_s      = {DATA_WIDTH{1'b0}};
        if (wr_s && (address == 2'd2)) begin
            irq_mask_d = writedata[DATA_WIDTH-1:0];
        end else begin
            irq_mask_d = irq_mask_q;
        end
        if (wr_s && (address == 2'd3)) begin
            clr_s = writedata[DATA_WIDTH-1:0];
        end else begin
            clr_s = {DATA_WIDTH{1'b0}};
        end
        edge_capture_d = (edge_capture_q & ~clr_s) | edge_s;
        irq_d          = |(edge_capture_d & irq_mask_d);
    end

    // Read mux uses pre-write register contents
    always_comb begin
        readdata_d = readdata_q;
        if (rd_s) begin
            readdata_d = 32'h0000_0000;
            case (address)
                2'd0:    readdata_d[DATA_WIDTH-1:0] = data_in_s;
                2'd1:    readdata_d[DATA_WIDTH-1:0] = snap_rd_s;
                2'd2:    readdata_d[DATA_WIDTH-1:0] = irq_mask_q;
                2'd3:    readdata_d[DATA_WIDTH-1:0] = edge_capture_q;
                default: readdata_d = 32'h0000_0000;
            endcase
        end else begin
            readdata_d = readdata_q;
        end
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_q       <= SETTLE_INIT;
            irq_mask_q     <= {DATA_WIDTH{1'b0}};
            edge_capture_q <= {DATA_WIDTH{1'b0}};
            readdata_q     <= 32'h0000_0000;
            irq_q          <= 1'b0;
        end else begin
            settle_q       <= settle_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
            irq_q          <= irq_d;
        end
    end

`ifdef CPU_RD_DATA_PIO_SNAPSHOT_EN
    logic [DATA_WIDTH-1:0] snap_q;
    logic [DATA_WIDTH-1:0] snap_d;

    // Snapshot arms only when the capture register leaves the all-zero state
    always_comb begin
        snap_d = snap_q;
        if ((edge_capture_q == {DATA_WIDTH{1'b0}}) && (edge_capture_d != {DATA_WIDTH{1'b0}})) begin
            snap_d = data_in_s;
        end else begin
            snap_d = snap_q;
        end
    end

    // Snapshot register
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_q <= {DATA_WIDTH{1'b0}};
        end else begin
            snap_q <= snap_d;
        end
    end

    assign snap_rd_s = snap_q;
`else
    assign snap_rd_s = {DATA_WIDTH{1'b0}};
`endif

endmodule
